// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives datapath selects, ALU/extender controls and write enables.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             dm_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       npc_sel,
    output logic             rf_we,
    output logic [1:0]       wrsel,
    output logic [1:0]       wdsel,
    output logic             bsel,
    output logic             ext_sign,
    output logic [2:0]       aluop,
    output logic             dm_re,
    output logic             dm_we,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t cur, nxt;

    // instruction classification from IR fields
    logic r_type, is_addu, is_subu, is_jr, is_j, is_jal;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_exec;

    assign r_type  = (op == 6'b000000);
    assign is_addu = r_type && (funct == 6'b100001);
    assign is_subu = r_type && (funct == 6'b100011);
    assign is_jr   = r_type && (funct == 6'b001000);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);
    assign is_beq  = (op == 6'b000100);
    assign is_ori  = (op == 6'b001101);
    assign is_lui  = (op == 6'b001111);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign is_exec = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw | is_beq;

    // ungated enables; reset forces them low combinationally
    logic ir_we_c, pc_we_c, rf_we_c, dm_re_c, dm_we_c, retire_c;

    assign ir_we  = ir_we_c  & ~reset;
    assign pc_we  = pc_we_c  & ~reset;
    assign rf_we  = rf_we_c  & ~reset;
    assign dm_re  = dm_re_c  & ~reset;
    assign dm_we  = dm_we_c  & ~reset;
    assign retire = retire_c & ~reset;
    assign state  = cur;

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    // retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       retire_cnt <= '0;
        else if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end

    // next-state and per-state control decode
    always_comb begin
        nxt      = FETCH;
        ir_we_c  = 1'b0;
        pc_we_c  = 1'b0;
        rf_we_c  = 1'b0;
        dm_re_c  = 1'b0;
        dm_we_c  = 1'b0;
        retire_c = 1'b0;
        npc_sel  = 2'b00;
        wrsel    = 2'b00;
        wdsel    = 2'b00;
        bsel     = 1'b0;
        ext_sign = 1'b0;
        aluop    = 3'b000;

        // MEM keeps the address computation of EXEC alive while waiting
        if (cur == EXEC || cur == MEM) begin
            if (is_subu || is_beq) aluop = 3'b001;
            if (is_ori) begin aluop = 3'b010; bsel = 1'b1; end
            if (is_lui) begin aluop = 3'b011; bsel = 1'b1; end
            if (is_lw || is_sw) begin bsel = 1'b1; ext_sign = 1'b1; end
        end

        case (cur)
            FETCH: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                nxt     = DECODE;
            end
            DECODE: begin
                if (is_j || is_jal) begin
                    pc_we_c  = 1'b1;
                    npc_sel  = 2'b10;
                    retire_c = 1'b1;
                    if (is_jal) begin
                        rf_we_c = 1'b1;
                        wrsel   = 2'b10;
                        wdsel   = 2'b10;
                    end
                end else if (is_jr) begin
                    pc_we_c  = 1'b1;
                    npc_sel  = 2'b11;
                    retire_c = 1'b1;
                end else if (is_exec) begin
                    nxt = EXEC;
                end else begin
                    retire_c = 1'b1;
                end
            end
            EXEC: begin
                if (is_beq) begin
                    pc_we_c  = zero;
                    npc_sel  = 2'b01;
                    retire_c = 1'b1;
                end else if (is_lw || is_sw) begin
                    nxt = MEM;
                end else begin
                    nxt = WB;
                end
            end
            MEM: begin
                dm_re_c = is_lw;
                dm_we_c = is_sw;
                if (!dm_ready)  nxt = MEM;
                else if (is_lw) nxt = WB;
                else            retire_c = 1'b1;
            end
            WB: begin
                rf_we_c  = 1'b1;
                retire_c = 1'b1;
                if (r_type) wrsel = 2'b01;
                if (is_lw)  wdsel = 2'b01;
            end
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus queues the expected per-cycle
// control vector, a negedge monitor pops and compares it against the DUT.
module tb_mc_ctrl;

    localparam int CW = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic zero = 1'b0, dm_ready = 1'b0;
    logic ir_we, pc_we, rf_we, bsel, ext_sign, dm_re, dm_we, retire;
    logic [1:0] npc_sel, wrsel, wdsel;
    logic [2:0] aluop, state;
    logic [CW-1:0] retire_cnt;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .dm_ready(dm_ready), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel),
        .rf_we(rf_we), .wrsel(wrsel), .wdsel(wdsel), .bsel(bsel),
        .ext_sign(ext_sign), .aluop(aluop), .dm_re(dm_re), .dm_we(dm_we),
        .state(state), .retire(retire), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic ir, pc;
        logic [1:0] npc;
        logic rf;
        logic [1:0] wr, wd;
        logic b, ex;
        logic [2:0] alu;
        logic re, we, ret;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    logic [CW-1:0] ecnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ev(input logic [2:0] st, input logic ir, pc, input logic [1:0] npc,
                                input logic rf, input logic [1:0] wr, wd, input logic b, ex,
                                input logic [2:0] alu, input logic re, we, ret);
        exp_t e;
        e = '{st, ir, pc, npc, rf, wr, wd, b, ex, alu, re, we, ret, '0};
        return e;
    endfunction

    // one cycle: drive inputs, queue expectation, advance to next posedge+1
    task automatic cyc(input exp_t e, input logic [5:0] o, f, input logic z, d);
        op = o; funct = f; zero = z; dm_ready = d;
        e.cnt = ecnt;
        q.push_back(e);
        if (e.ret) ecnt = ecnt + 1'b1;
        @(posedge clk); #1;
    endtask

    exp_t F, D;
    initial begin
        F = ev(3'd0, 1,1,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,0,0);
        D = ev(3'd1, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,0,0);
    end

    // monitor: compare every cycle for which an expectation is queued
    always @(negedge clk) begin
        if (!reset && q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = q.pop_front();
            a = '{state, ir_we, pc_we, npc_sel, rf_we, wrsel, wdsel, bsel, ext_sign,
                  aluop, dm_re, dm_we, retire, retire_cnt};
            chk($sformatf("cycle st%0d", e.st), 64'(a), 64'(e));
        end
    end

    localparam logic [5:0] RT = 6'b000000, NOPF = 6'b000000;

    initial begin
        // reset state
        #2;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_en", 64'({ir_we, pc_we, rf_we, dm_re, dm_we, retire}), 64'd0);
        chk("rst_cnt", 64'(retire_cnt), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // sw, reset pulsed during MEM
        cyc(F, 6'b101011, NOPF, 0, 0);
        cyc(D, 6'b101011, NOPF, 0, 0);
        cyc(ev(3'd2, 0,0,2'b00, 0,2'b00,2'b00, 1,1,3'b000, 0,0,0), 6'b101011, NOPF, 0, 0);
        q.push_back(ev(3'd3, 0,0,2'b00, 0,2'b00,2'b00, 1,1,3'b000, 0,1,0));
        @(negedge clk); #2;
        reset = 1'b1; #1;
        chk("swrst_dm_we", 64'(dm_we), 64'd0);
        chk("swrst_state", 64'(state), 64'd0);
        chk("swrst_retire", 64'(retire), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("swrst_cnt", 64'(retire_cnt), 64'd0);

        // addu
        cyc(F, RT, 6'b100001, 0, 1);
        cyc(D, RT, 6'b100001, 0, 1);
        cyc(ev(3'd2, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,0,0), RT, 6'b100001, 0, 1);
        cyc(ev(3'd4, 0,0,2'b00, 1,2'b01,2'b00, 0,0,3'b000, 0,0,1), RT, 6'b100001, 0, 1);

        // lw with three wait cycles
        cyc(F, 6'b100011, NOPF, 0, 0);
        cyc(D, 6'b100011, NOPF, 0, 0);
        cyc(ev(3'd2, 0,0,2'b00, 0,2'b00,2'b00, 1,1,3'b000, 0,0,0), 6'b100011, NOPF, 0, 0);
        for (int i = 0; i < 4; i++)
            cyc(ev(3'd3, 0,0,2'b00, 0,2'b00,2'b00, 1,1,3'b000, 1,0,0), 6'b100011, NOPF, 0, (i == 3));
        cyc(ev(3'd4, 0,0,2'b00, 1,2'b00,2'b01, 0,0,3'b000, 0,0,1), 6'b100011, NOPF, 0, 1);

        // beq taken / not taken
        for (int z = 1; z >= 0; z--) begin
            cyc(F, 6'b000100, NOPF, z[0], 1);
            cyc(D, 6'b000100, NOPF, z[0], 1);
            cyc(ev(3'd2, 0,z[0],2'b01, 0,2'b00,2'b00, 0,0,3'b001, 0,0,1), 6'b000100, NOPF, z[0], 1);
        end

        // jal, j, jr
        cyc(F, 6'b000011, NOPF, 0, 1);
        cyc(ev(3'd1, 0,1,2'b10, 1,2'b10,2'b10, 0,0,3'b000, 0,0,1), 6'b000011, NOPF, 0, 1);
        cyc(F, 6'b000010, NOPF, 0, 1);
        cyc(ev(3'd1, 0,1,2'b10, 0,2'b00,2'b00, 0,0,3'b000, 0,0,1), 6'b000010, NOPF, 0, 1);
        cyc(F, RT, 6'b001000, 0, 1);
        cyc(ev(3'd1, 0,1,2'b11, 0,2'b00,2'b00, 0,0,3'b000, 0,0,1), RT, 6'b001000, 0, 1);

        // ori
        cyc(F, 6'b001101, NOPF, 0, 1);
        cyc(D, 6'b001101, NOPF, 0, 1);
        cyc(ev(3'd2, 0,0,2'b00, 0,2'b00,2'b00, 1,0,3'b010, 0,0,0), 6'b001101, NOPF, 0, 1);
        cyc(ev(3'd4, 0,0,2'b00, 1,2'b00,2'b00, 0,0,3'b000, 0,0,1), 6'b001101, NOPF, 0, 1);

        // lui
        cyc(F, 6'b001111, NOPF, 0, 1);
        cyc(D, 6'b001111, NOPF, 0, 1);
        cyc(ev(3'd2, 0,0,2'b00, 0,2'b00,2'b00, 1,0,3'b011, 0,0,0), 6'b001111, NOPF, 0, 1);
        cyc(ev(3'd4, 0,0,2'b00, 1,2'b00,2'b00, 0,0,3'b000, 0,0,1), 6'b001111, NOPF, 0, 1);

        // subu
        cyc(F, RT, 6'b100011, 0, 1);
        cyc(D, RT, 6'b100011, 0, 1);
        cyc(ev(3'd2, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b001, 0,0,0), RT, 6'b100011, 0, 1);
        cyc(ev(3'd4, 0,0,2'b00, 1,2'b01,2'b00, 0,0,3'b000, 0,0,1), RT, 6'b100011, 0, 1);

        // sw, memory ready at once
        cyc(F, 6'b101011, NOPF, 0, 1);
        cyc(D, 6'b101011, NOPF, 0, 1);
        cyc(ev(3'd2, 0,0,2'b00, 0,2'b00,2'b00, 1,1,3'b000, 0,0,0), 6'b101011, NOPF, 0, 1);
        cyc(ev(3'd3, 0,0,2'b00, 0,2'b00,2'b00, 1,1,3'b000, 0,1,1), 6'b101011, NOPF, 0, 1);

        // unsupported opcode and unsupported R funct retire as NOPs;
        // the extra NOPs carry the 4-bit counter across 15 -> 0
        cyc(F, 6'b111111, NOPF, 0, 1);
        cyc(ev(3'd1, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,0,1), 6'b111111, NOPF, 0, 1);
        cyc(F, RT, 6'b000000, 0, 1);
        cyc(ev(3'd1, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,0,1), RT, 6'b000000, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(F, 6'b111111, NOPF, 0, 1);
            cyc(ev(3'd1, 0,0,2'b00, 0,2'b00,2'b00, 0,0,3'b000, 0,0,1), 6'b111111, NOPF, 0, 1);
        end
        cyc(F, 6'b111111, NOPF, 0, 1);
        chk("wrap_cnt", 64'(retire_cnt), 64'd0);

        // drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #1;
        chk("sb_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
